pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised program-counter / fetch sequencer; successor to the single-cycle pc block.
//  Holds PCaddr and runs a two-state fetch/execute handshake with instruction memory.
//  Resolves JAL/JALR/branches from cuOP and ALU flags, and provides the link address.
//  Counts retired instructions and supports a halt. Sits between the control unit/ALU and imem.
// PARAMETERS
//  XLEN       32  address/data width
//  RESET_VEC  0   PC value loaded by reset; must be 4-byte aligned
//  CNT_W      32  width of retired-instruction counter
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  RST            in   1      synchronous reset, active-high
//  cuOP           in   6      cuOPType encoding: LUI=0 AUIPC=1 JAL=2 JALR=3 BEQ=4 BNE=5 BLT=6 BGE=7 BLTU=8 BGEU=9
//  rs1Read        in   XLEN   rs1 operand (JALR base)
//  signExtend     in   XLEN   sign-extended immediate
//  ALUneg         in   1      ALU compare result: signed less-than for BLT/BGE, unsigned borrow for BLTU/BGEU
//  Zero           in   1      ALU result == 0 (rs1 == rs2)
//  iready         in   1      execute stage done; operands/flags valid this cycle
//  halt           in   1      stop after current instruction (ECALL/EBREAK path)
//  imem_ack       in   1      imem has returned the instruction for imem_addr
//  imem_req       out  1      fetch request
//  imem_addr      out  XLEN   fetch address (== PCaddr)
//  instr_valid    out  1      fetched instruction held, execute may proceed
//  PCaddr         out  XLEN   current PC
//  PClink         out  XLEN   PCaddr + 4 (rd value for JAL/JALR)
//  taken          out  1      1-cycle pulse: last retire redirected (jump or taken branch)
//  halted         out  1      in HALT state
//  instret        out  CNT_W  retired instruction count
//  misalign_trap  out  1      only when PC_MISALIGN_TRAP_EN defined
// BEHAVIOUR
//  - Reset (RST high at edge): PCaddr=RESET_VEC, state=FETCH, taken=0, instret=0, misalign_trap=0.
//    Reset wins over every other input; reset mid-fetch/mid-execute abandons the instruction.
//  - Outputs decoded from state: imem_req=(FETCH), instr_valid=(EXEC), halted=(HALT).
//    First cycle after reset: imem_req=1, imem_addr=RESET_VEC.
//  - FETCH: hold imem_req/imem_addr stable until imem_ack; on ack -> EXEC (1 cycle min).
//  - EXEC: wait for iready; imem_ack ignored. On iready: PCaddr<=next, instret<=instret+1,
//    taken<=redirect; then -> HALT if halt else FETCH. Min loop: 2 cycles/instruction.
//  - HALT: PC, instret frozen; all inputs ignored; exit only via RST. halt outside EXEC ignored.
//  - next PC (all sums mod 2^XLEN, wrap silently, e.g. 0xFFFFFFFC+4=0):
//    JAL: PCaddr+signExtend; JALR: (rs1Read+signExtend) & ~1;
//    BEQ Zero; BNE !Zero; BLT/BLTU ALUneg; BGE/BGEU !ALUneg -> taken: PCaddr+signExtend, else PCaddr+4;
//    any other cuOP (incl. CU_ERROR): PCaddr+4, redirect=0.
//  - redirect=1 for JAL, JALR, taken branch; taken is registered, high exactly 1 cycle after retire.
//  - PClink combinational from PCaddr. instret wraps at 2^CNT_W.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: at retire, if redirect and target[1:0]!=0, PCaddr not updated,
//    instret not incremented, misalign_trap<=1 (sticky until RST), state -> HALT.
//  Not defined: port absent, target used verbatim (JALR bit0 still cleared), no trap.
// TESTING
//  1 Reset: RST=1 two cycles mid-EXEC -> PCaddr=0, imem_req=1, instret=0, taken=0.
//  2 Sequential: ack each fetch 1 cycle later, cuOP=ADDI x3 -> PCaddr 0,4,8,12; instret=3; taken=0.
//  3 JAL imm=0x100 at PC=8 -> PCaddr=0x108, PClink=0xC before retire, taken pulse 1 cycle;
//    JALR rs1=0x203 imm=2 -> PCaddr=0x204.
//  4 Branches at PC=0x40 imm=-16: BEQ Zero=1 -> 0x30; BEQ Zero=0 -> 0x44; BGEU ALUneg=0 -> 0x30;
//    BLTU ALUneg=0 -> 0x44.
//  5 Stalls: imem_ack delayed 5 cycles, iready delayed 3 -> imem_addr stable, PC changes once;
//    RESET_VEC=0xFFFFFFFC, ADDI -> PCaddr=0.
//  6 halt with iready at PC=0x10 -> PCaddr=0x14, halted=1, further iready/ack ignored;
//    with PC_MISALIGN_TRAP_EN, JAL imm=6 -> misalign_trap=1, PCaddr unchanged.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: control-unit/ALU inputs, imem handshake and PC/status outputs.
// misalign_trap exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_fetch_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       cuOP;
  logic [XLEN-1:0]  rs1Read;
  logic [XLEN-1:0]  signExtend;
  logic             ALUneg;
  logic             Zero;
  logic             iready;
  logic             halt;
  logic             imem_ack;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             instr_valid;
  logic [XLEN-1:0]  PCaddr;
  logic [XLEN-1:0]  PClink;
  logic             taken;
  logic             halted;
  logic [CNT_W-1:0] instret;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misalign_trap;
`endif

  modport slave (
    input  cuOP, rs1Read, signExtend, ALUneg, Zero, iready, halt, imem_ack,
`ifdef PC_MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output imem_req, imem_addr, instr_valid, PCaddr, PClink, taken, halted, instret
  );

  modport master (
    output cuOP, rs1Read, signExtend, ALUneg, Zero, iready, halt, imem_ack,
`ifdef PC_MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  imem_req, imem_addr, instr_valid, PCaddr, PClink, taken, halted, instret
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer: FETCH/EXEC/HALT handshake, jump/branch resolution,
// retired-instruction counter. Optional misaligned-target trap under PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     CNT_W     = 32
) (
  input logic             clk,
  input logic             RST,
  pc_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StFetch = 2'd0, StExec = 2'd1, StHalt = 2'd2} state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_instret;
  logic             r_taken;

  logic [XLEN-1:0]  w_seq;
  logic [XLEN-1:0]  w_rel;
  logic [XLEN-1:0]  w_jalr;
  logic [XLEN-1:0]  w_next;
  logic             w_redirect;
  logic             w_is_br;
  logic             w_cond;
  logic             w_trap;

  always_comb begin
    w_seq      = r_pc + XLEN'(4);
    w_rel      = r_pc + bus.signExtend;
    w_jalr     = (bus.rs1Read + bus.signExtend) & ~XLEN'(1);
    w_next     = w_seq;
    w_redirect = 1'b0;
    w_is_br    = 1'b0;
    w_cond     = 1'b0;
    case (bus.cuOP)
      6'd2: begin w_redirect = 1'b1; w_next = w_rel;  end
      6'd3: begin w_redirect = 1'b1; w_next = w_jalr; end
      6'd4: begin w_is_br = 1'b1; w_cond = bus.Zero;    end
      6'd5: begin w_is_br = 1'b1; w_cond = !bus.Zero;   end
      6'd6, 6'd8: begin w_is_br = 1'b1; w_cond = bus.ALUneg;  end
      6'd7, 6'd9: begin w_is_br = 1'b1; w_cond = !bus.ALUneg; end
      default: ;
    endcase
    if (w_is_br && w_cond) begin
      w_redirect = 1'b1;
      w_next     = w_rel;
    end
`ifdef PC_MISALIGN_TRAP_EN
    w_trap = w_redirect && (w_next[1:0] != 2'b00);
`else
    w_trap = 1'b0;
`endif
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_trap;
  assign bus.misalign_trap = r_trap;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state   <= StFetch;
      r_pc      <= RESET_VEC;
      r_instret <= '0;
      r_taken   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      r_trap    <= 1'b0;
`endif
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        StFetch: if (bus.imem_ack) r_state <= StExec;
        StExec: begin
          if (bus.iready) begin
            if (w_trap) begin
              // Faulting target: keep PC and count, park in HALT.
`ifdef PC_MISALIGN_TRAP_EN
              r_trap  <= 1'b1;
`endif
              r_state <= StHalt;
            end else begin
              r_pc      <= w_next;
              r_instret <= r_instret + CNT_W'(1);
              r_taken   <= w_redirect;
              r_state   <= bus.halt ? StHalt : StFetch;
            end
          end
        end
        StHalt:  ;
        default: r_state <= StFetch;
      endcase
    end
  end

  assign bus.imem_req    = (r_state == StFetch);
  assign bus.instr_valid = (r_state == StExec);
  assign bus.halted      = (r_state == StHalt);
  assign bus.imem_addr   = r_pc;
  assign bus.PCaddr      = r_pc;
  assign bus.PClink      = w_seq;
  assign bus.taken       = r_taken;
  assign bus.instret     = r_instret;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a spec-level PC model.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus ();
  pc_fetch_ctrl_if bus2 ();

  pc_fetch_ctrl #(.XLEN(32), .RESET_VEC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .RST(RST), .bus(bus.slave)
  );
  pc_fetch_ctrl #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .CNT_W(32)) dut2 (
    .clk(clk), .RST(RST), .bus(bus2.slave)
  );

  // Second instance runs in lockstep on the same inputs.
  assign bus2.cuOP       = bus.cuOP;
  assign bus2.rs1Read    = bus.rs1Read;
  assign bus2.signExtend = bus.signExtend;
  assign bus2.ALUneg     = bus.ALUneg;
  assign bus2.Zero       = bus.Zero;
  assign bus2.iready     = bus.iready;
  assign bus2.halt       = bus.halt;
  assign bus2.imem_ack   = bus.imem_ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  bit          m_halt;
  bit          m_trap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_target(input logic [5:0] op, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [31:0] rs1,
                                             input bit z, input bit n, output bit redir);
    logic [31:0] t;
    redir = 1'b0;
    case (op)
      6'd2: begin redir = 1'b1; return pc + imm; end
      6'd3: begin redir = 1'b1; t = rs1 + imm; t[0] = 1'b0; return t; end
      6'd4: redir = z;
      6'd5: redir = !z;
      6'd6, 6'd8: redir = n;
      6'd7, 6'd9: redir = !n;
      default: redir = 1'b0;
    endcase
    return redir ? pc + imm : pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    bus.cuOP = 6'd0; bus.rs1Read = '0; bus.signExtend = '0;
    bus.ALUneg = 1'b0; bus.Zero = 1'b0; bus.iready = 1'b0;
    bus.halt = 1'b0; bus.imem_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    idle_inputs();
    repeat (n) step();
    RST = 1'b0;
    m_pc = 32'h0; m_ret = 32'h0; m_halt = 1'b0; m_trap = 1'b0;
    chk("rst_pc", bus.PCaddr, 32'h0);
    chk("rst_req", bus.imem_req, 1'b1);
    chk("rst_instret", bus.instret, 32'h0);
    chk("rst_taken", bus.taken, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] rs1,
                     input bit z, input bit n, input int ad, input int rd, input bit h);
    bit redir, trap, exp_taken;
    logic [31:0] tgt;
    bus.imem_ack = 1'b0;
    chk("fetch_req", bus.imem_req, 1'b1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    repeat (ad) begin
      bus.iready = 1'($urandom_range(0, 1));
      step();
      chk("addr_stable", bus.imem_addr, m_pc);
      chk("fetch_hold", bus.imem_req, 1'b1);
    end
    bus.iready = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("exec_valid", bus.instr_valid, 1'b1);
    chk("taken_clear", bus.taken, 1'b0);
    chk("exec_pc", bus.PCaddr, m_pc);
    chk("pclink", bus.PClink, m_pc + 32'd4);
    bus.cuOP = op; bus.signExtend = imm; bus.rs1Read = rs1; bus.Zero = z; bus.ALUneg = n;
    repeat (rd) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      step();
      chk("exec_hold_pc", bus.PCaddr, m_pc);
    end
    bus.imem_ack = 1'b0;
    bus.iready = 1'b1;
    bus.halt = h;
    step();
    bus.iready = 1'b0;
    bus.halt = 1'b0;
    tgt = ref_target(op, m_pc, imm, rs1, z, n, redir);
`ifdef PC_MISALIGN_TRAP_EN
    trap = redir && (tgt[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    if (trap) begin
      m_trap = 1'b1; m_halt = 1'b1; exp_taken = 1'b0;
    end else begin
      m_pc = tgt; m_ret = m_ret + 32'd1; m_halt = h; exp_taken = redir;
    end
    chk("ret_pc", bus.PCaddr, m_pc);
    chk("ret_instret", bus.instret, m_ret);
    chk("ret_taken", bus.taken, exp_taken);
    chk("ret_halted", bus.halted, m_halt);
    chk("ret_req", bus.imem_req, !m_halt);
`ifdef PC_MISALIGN_TRAP_EN
    chk("ret_trap", bus.misalign_trap, m_trap);
`endif
  endtask

  task automatic goto_pc(input logic [31:0] target);
    run(6'd2, target - m_pc, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] imm, rs1;

    do_reset(2);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst2_pc", bus2.PCaddr, 32'hFFFF_FFFC);

    // Reset held two cycles while in EXEC, with iready asserted.
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("midexec_valid", bus.instr_valid, 1'b1);
    RST = 1'b1;
    bus.iready = 1'b1;
    bus.cuOP = 6'd2;
    bus.signExtend = 32'h100;
    step();
    step();
    RST = 1'b0;
    idle_inputs();
    chk("midrst_pc", bus.PCaddr, 32'h0);
    chk("midrst_req", bus.imem_req, 1'b1);
    chk("midrst_instret", bus.instret, 32'h0);
    chk("midrst_taken", bus.taken, 1'b0);

    // Sequential ADDIs; dut2 wraps 0xFFFFFFFC -> 0.
    run(6'd10, 32'h5, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    chk("wrap_pc", bus2.PCaddr, 32'h0);
    chk("wrap_instret", bus2.instret, 32'h1);
    run(6'd10, 32'h5, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    run(6'd10, 32'h5, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    chk("seq_pc", bus.PCaddr, 32'hC);
    chk("seq_instret", bus.instret, 32'h3);

    // JAL / JALR.
    do_reset(1);
    run(6'd10, 32'h0, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    run(6'd10, 32'h0, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    run(6'd2, 32'h100, 32'h0, 1'b0, 1'b0, 0, 1, 1'b0);
    chk("jal_pc", bus.PCaddr, 32'h108);
    chk("jal_taken", bus.taken, 1'b1);
    run(6'd3, 32'h2, 32'h203, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("jalr_pc", bus.PCaddr, 32'h204);

    // Branches at 0x40 with imm = -16.
    goto_pc(32'h40);
    run(6'd4, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("beq_t", bus.PCaddr, 32'h30);
    goto_pc(32'h40);
    run(6'd4, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("beq_nt", bus.PCaddr, 32'h44);
    chk("beq_nt_taken", bus.taken, 1'b0);
    goto_pc(32'h40);
    run(6'd9, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("bgeu_t", bus.PCaddr, 32'h30);
    goto_pc(32'h40);
    run(6'd8, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("bltu_nt", bus.PCaddr, 32'h44);

    // Stalls on both handshakes.
    run(6'd10, 32'h0, 32'h0, 1'b0, 1'b0, 5, 3, 1'b0);
    chk("stall_pc", bus.PCaddr, 32'h48);

    // Halt at 0x10, then everything ignored.
    goto_pc(32'h10);
    run(6'd10, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("halt_pc", bus.PCaddr, 32'h14);
    chk("halt_flag", bus.halted, 1'b1);
    repeat (6) begin
      bus.iready = 1'b1; bus.imem_ack = 1'b1; bus.halt = 1'($urandom_range(0, 1));
      bus.cuOP = 6'd2; bus.signExtend = $urandom;
      step();
      chk("halt_frozen_pc", bus.PCaddr, 32'h14);
      chk("halt_frozen_ret", bus.instret, m_ret);
      chk("halt_stays", bus.halted, 1'b1);
      chk("halt_noreq", bus.imem_req, 1'b0);
    end

    // Misaligned JAL target.
    do_reset(1);
    run(6'd2, 32'h6, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_flag", bus.misalign_trap, 1'b1);
    chk("trap_pc", bus.PCaddr, 32'h0);
    chk("trap_ret", bus.instret, 32'h0);
`else
    chk("misalign_pc", bus.PCaddr, 32'h6);
`endif

    // Randomized instruction stream.
    do_reset(1);
    repeat (60) begin
      op  = 6'($urandom_range(0, 12));
      imm = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom & 32'hFFFF_FFFD;
      run(op, imm, rs1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 15) == 0));
      if (m_halt) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
